// File: rtl/block_scroller_pkg.sv
// Shared constants and state encoding for the obstacle scroller and its shape generator.
package block_scroller_pkg;

  localparam int COORD_W    = 10;   // coordinate length
  localparam int SHAPE_W    = 4;    // shape-encode length
  localparam int SCREEN_W   = 640;  // visible width, doubles as off-screen X
  localparam int NUM_SHAPES = 11;   // legal shape codes 0..NUM_SHAPES-1
  localparam int BLOCK_W    = 32;   // obstacle pixel width used by the renderer

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    SPAWN
  } state_t;

endpackage

// File: rtl/block_scroller_shape_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) folded into a legal shape code.
module shape_lfsr
  import block_scroller_pkg::*;
#(
  parameter int SHAPE_W    = block_scroller_pkg::SHAPE_W,
  parameter int NUM_SHAPES = block_scroller_pkg::NUM_SHAPES
) (
  input  logic               CLK,
  input  logic               RST,
  output logic [SHAPE_W-1:0] SHAPE
);

  logic [7:0] lfsr;
  logic [3:0] v;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // One conditional subtract maps 0..15 onto 0..10 since 15-11 < 11.
  assign v     = lfsr[3:0];
  assign SHAPE = SHAPE_W'((v >= 4'(NUM_SHAPES)) ? v - 4'(NUM_SHAPES) : v);

endmodule

// File: rtl/block_scroller.sv
// Scrolls obstacle slots left once per accepted frame tick, one slot per cycle,
// then optionally spawns a new obstacle at the right edge.
module block_scroller
  import block_scroller_pkg::*;
#(
  parameter int COORD_W    = block_scroller_pkg::COORD_W,
  parameter int SHAPE_W    = block_scroller_pkg::SHAPE_W,
  parameter int NUM_SLOTS  = 4,
  parameter int SCREEN_W   = block_scroller_pkg::SCREEN_W,
  parameter int PLAYER_X   = 160,
  parameter int SPAWN_GAP  = 200,
  parameter int NUM_SHAPES = block_scroller_pkg::NUM_SHAPES
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         FRAME_TICK,
  input  logic                         RUN,
  input  logic [2:0]                   SPEED,
  output logic [NUM_SLOTS*COORD_W-1:0] BLOCK_X,
  output logic [NUM_SLOTS*SHAPE_W-1:0] BLOCK_SHAPE,
  output logic [NUM_SLOTS-1:0]         BLOCK_VALID,
  output logic                         BUSY,
  output logic                         PASS_PULSE
);

  localparam int                 IDX_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_SLOTS - 1);
  localparam logic [COORD_W-1:0] X_OFF    = COORD_W'(SCREEN_W);
  localparam logic [COORD_W-1:0] X_SPAWN  = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] X_PLAYER = COORD_W'(PLAYER_X);
  localparam logic [COORD_W-1:0] GAP_MIN  = COORD_W'(SPAWN_GAP);

  state_t state, state_nxt;

  logic [IDX_W-1:0]   idx;
  logic [2:0]         speed_q;
  logic [COORD_W-1:0] gap;
  logic               busy_q;
  logic               pass_q;
  logic [COORD_W-1:0] x_q     [NUM_SLOTS];
  logic [SHAPE_W-1:0] shape_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_q;

  logic [SHAPE_W-1:0] shape;

  shape_lfsr #(
    .SHAPE_W   (SHAPE_W),
    .NUM_SHAPES(NUM_SHAPES)
  ) u_shape_lfsr (
    .CLK  (CLK),
    .RST  (RST),
    .SHAPE(shape)
  );

  // NOTE: every flop here updates with <= so all registers see pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
    end
  end

  // NOTE: every always_comb output is assigned a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (FRAME_TICK && RUN) state_nxt = UPDATE;
      UPDATE:  if (idx == LAST_IDX)   state_nxt = SPAWN;
      SPAWN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-slot move/retire decision for the slot addressed by idx.
  logic [COORD_W-1:0] cur_x, new_x;
  logic               cur_v, retire, pass_now;

  always_comb begin
    cur_x    = x_q[idx];
    cur_v    = valid_q[idx];
    retire   = cur_v && (cur_x < COORD_W'(speed_q));
    new_x    = retire ? '0 : cur_x - COORD_W'(speed_q);
    pass_now = cur_v && (cur_x >= X_PLAYER) && (new_x < X_PLAYER);
  end

  // Spawn decision: saturating gap and lowest-index free slot.
  logic [COORD_W:0]   gap_wide;
  logic [COORD_W-1:0] gap_sum;
  logic [IDX_W-1:0]   free_idx;
  logic               free_found, spawn_ok;

  always_comb begin
    gap_wide   = {1'b0, gap} + (COORD_W+1)'(speed_q);
    gap_sum    = gap_wide[COORD_W] ? '1 : gap_wide[COORD_W-1:0];
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
    spawn_ok = free_found && (gap_sum >= GAP_MIN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the slot array is small and drives outputs directly, so it takes the async reset.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i]     <= X_OFF;
        shape_q[i] <= '0;
      end
      valid_q <= '0;
      idx     <= '0;
      speed_q <= '0;
      gap     <= GAP_MIN;
      pass_q  <= 1'b0;
    end else begin
      pass_q <= 1'b0;
      case (state)
        IDLE: begin
          if (FRAME_TICK && RUN) begin
            speed_q <= SPEED;
            idx     <= '0;
          end
        end
        UPDATE: begin
          if (cur_v) begin
            x_q[idx] <= retire ? X_OFF : new_x;
            if (retire) valid_q[idx] <= 1'b0;
          end
          pass_q <= pass_now;
          idx    <= idx + 1'b1;
        end
        SPAWN: begin
          if (spawn_ok) begin
            x_q[free_idx]     <= X_SPAWN;
            shape_q[free_idx] <= shape;
            valid_q[free_idx] <= 1'b1;
            gap               <= '0;
          end else begin
            gap <= gap_sum;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign BLOCK_X[g*COORD_W +: COORD_W]     = x_q[g];
    assign BLOCK_SHAPE[g*SHAPE_W +: SHAPE_W] = shape_q[g];
  end

  assign BLOCK_VALID = valid_q;
  assign BUSY        = busy_q;
  assign PASS_PULSE  = pass_q;

endmodule

// File: tb/tb_block_scroller.sv
// Bench for block_scroller: a default instance and a short-spawn-gap instance share stimulus
// and are compared against a frame-level reference model.
module tb_block_scroller;

  logic        CLK, RST, FRAME_TICK, RUN;
  logic [2:0]  SPEED;
  logic [39:0] bx   [2];
  logic [15:0] bs   [2];
  logic [3:0]  bv   [2];
  logic        busy [2];
  logic        pp   [2];

  int n_checks = 0;
  int n_err    = 0;

  block_scroller dut (
    .CLK(CLK), .RST(RST), .FRAME_TICK(FRAME_TICK), .RUN(RUN), .SPEED(SPEED),
    .BLOCK_X(bx[0]), .BLOCK_SHAPE(bs[0]), .BLOCK_VALID(bv[0]),
    .BUSY(busy[0]), .PASS_PULSE(pp[0])
  );

  block_scroller #(.SPAWN_GAP(40)) dut_sat (
    .CLK(CLK), .RST(RST), .FRAME_TICK(FRAME_TICK), .RUN(RUN), .SPEED(SPEED),
    .BLOCK_X(bx[1]), .BLOCK_SHAPE(bs[1]), .BLOCK_VALID(bv[1]),
    .BUSY(busy[1]), .PASS_PULSE(pp[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference LFSR from the polynomial description: taps 8,6,5,4 -> bits 7,5,4,3.
  logic [7:0] m_lfsr;
  always @(posedge CLK or posedge RST) begin
    if (RST) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // Frame-level model state per instance.
  int mx [2][4];
  int mv [2][4];
  int ms [2][4];
  int mg [2];
  int gap_lim [2] = '{200, 40};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int fold(input int v);
    return (v >= 11) ? v - 11 : v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        mx[d][i] = 640;
        mv[d][i] = 0;
        ms[d][i] = 0;
      end
      mg[d] = gap_lim[d];
    end
  endtask

  task automatic model_frame(input int d, input int spd, input logic [7:0] lf, output int passes);
    int nx;
    passes = 0;
    for (int i = 0; i < 4; i++) begin
      if (mv[d][i] != 0) begin
        nx = (mx[d][i] >= spd) ? mx[d][i] - spd : 0;
        if (mx[d][i] >= 160 && nx < 160) passes++;
        if (mx[d][i] < spd) begin
          mx[d][i] = 640;
          mv[d][i] = 0;
        end else begin
          mx[d][i] = nx;
        end
      end
    end
    mg[d] = (mg[d] + spd > 1023) ? 1023 : mg[d] + spd;
    if (mg[d] >= gap_lim[d]) begin
      for (int i = 0; i < 4; i++) begin
        if (mv[d][i] == 0) begin
          mx[d][i] = 639;
          mv[d][i] = 1;
          ms[d][i] = fold(int'(lf[3:0]));
          mg[d]    = 0;
          break;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s d%0d x%0d", tag, d, i), 32'(bx[d][i*10 +: 10]), 32'(mx[d][i]));
        check($sformatf("%s d%0d v%0d", tag, d, i), 32'(bv[d][i]), 32'(mv[d][i]));
        check($sformatf("%s d%0d s%0d", tag, d, i), 32'(bs[d][i*4 +: 4]), 32'(ms[d][i]));
      end
      check($sformatf("%s d%0d busy", tag, d), 32'(busy[d]), 32'd0);
    end
  endtask

  // One frame: tick, observe a fixed window of cycles, then compare with the model.
  // RUN/SPEED are scrambled after the tick to show the sampled speed is held.
  task automatic do_frame(input bit run, input int spd, input bit extra, output int p0);
    int pulses [2];
    int bcnt   [2];
    int exp_p;
    logic [7:0] spawn_lf;
    pulses   = '{0, 0};
    bcnt     = '{0, 0};
    spawn_lf = 8'h00;
    @(negedge CLK);
    FRAME_TICK = 1'b1;
    RUN        = run;
    SPEED      = spd[2:0];
    @(negedge CLK);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge CLK);
      FRAME_TICK = (extra && run && k == 1);
      RUN        = (extra && run && k == 1) ? 1'b1 : 1'($urandom);
      SPEED      = 3'($urandom);
      for (int d = 0; d < 2; d++) begin
        if (busy[d]) bcnt[d]++;
        if (pp[d])   pulses[d]++;
      end
      if (busy[0]) spawn_lf = m_lfsr;
    end
    FRAME_TICK = 1'b0;
    for (int d = 0; d < 2; d++) begin
      exp_p = 0;
      if (run) model_frame(d, spd, spawn_lf, exp_p);
      check($sformatf("busy cycles d%0d", d), 32'(bcnt[d]), run ? 32'd5 : 32'd0);
      check($sformatf("pass pulses d%0d", d), 32'(pulses[d]), 32'(exp_p));
    end
    compare_all("frame");
    p0 = pulses[0];
  endtask

  typedef struct {
    int reps;
    bit run;
    int spd;
    int exp_x0;
    int exp_v0;
    int exp_pass;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int p0;
    bit run, extra;
    tbl[0] = '{1,  1'b1, 4, 639, 1, 0};  // first spawn after reset
    tbl[1] = '{68, 1'b1, 7, 163, 1, 0};
    tbl[2] = '{1,  1'b1, 1, 162, 1, 0};
    tbl[3] = '{1,  1'b1, 4, 158, 1, 1};  // crosses the player column
    tbl[4] = '{1,  1'b1, 4, 154, 1, 0};
    tbl[5] = '{21, 1'b1, 7, 7,   1, 0};
    tbl[6] = '{1,  1'b1, 4, 3,   1, 0};
    tbl[7] = '{1,  1'b1, 4, 640, 0, 0};  // retires, below the player so no pass
    tbl[8] = '{1,  1'b0, 5, 640, 0, 0};  // RUN=0 tick ignored
    tbl[9] = '{1,  1'b1, 0, 640, 0, 0};  // SPEED=0 still runs the sequence

    RST = 1'b1; FRAME_TICK = 1'b0; RUN = 1'b0; SPEED = 3'd0;
    model_reset();
    #1;
    compare_all("reset");
    check("reset pass", 32'(pp[0]), 32'd0);
    #20;
    @(negedge CLK);
    RST = 1'b0;

    for (int r = 0; r < 10; r++) begin
      for (int n = 0; n < tbl[r].reps; n++) do_frame(tbl[r].run, tbl[r].spd, 1'b0, p0);
      check($sformatf("tbl%0d x0", r), 32'(bx[0][9:0]), 32'(tbl[r].exp_x0));
      check($sformatf("tbl%0d v0", r), 32'(bv[0][0]), 32'(tbl[r].exp_v0));
      check($sformatf("tbl%0d pass", r), 32'(p0), 32'(tbl[r].exp_pass));
      if (r == 0) check("first shape range", 32'(bs[0][3:0] <= 4'd10), 32'd1);
    end

    // Double tick: the second tick lands mid-sequence and must not start another frame.
    do_frame(1'b1, 6, 1'b1, p0);

    // Randomised frames; the short-gap instance fills all slots and refills retirees.
    for (int n = 0; n < 200; n++) begin
      run   = ($urandom_range(0, 9) != 0);
      extra = run && ($urandom_range(0, 4) == 0);
      do_frame(run, int'($urandom_range(0, 7)), extra, p0);
    end

    // Reset while slot 2 is being processed.
    @(negedge CLK);
    FRAME_TICK = 1'b1; RUN = 1'b1; SPEED = 3'd4;
    @(negedge CLK);
    FRAME_TICK = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
    #1;
    compare_all("mid reset");
    check("mid reset pass", 32'(pp[0]), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    compare_all("post reset idle");
    do_frame(1'b1, 4, 1'b0, p0);
    check("post reset spawn v0", 32'(bv[0][0]), 32'd1);
    check("post reset spawn x0", 32'(bx[0][9:0]), 32'd639);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
